min_pair_merger: RTL and testbench

Merges successive (min, second-min) magnitude pairs from the 4-input rank-order sorter into one running pair per check-node row, for rows wider than four edges. Sits directly downstream of the sorter. Consumes one sorter group per cycle under a valid/ready handshake. Emits the row's min1, min2, min1 group index, sign parity and group count as one registered result with an optional saturating min-sum offset.

---
 rtl/min_pair_merger_if.sv | 36 +++
 rtl/min_pair_merger.sv | 125 ++++++++++++
 tb/tb_min_pair_merger.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/min_pair_merger_if.sv
// Handshake bundle between the rank-order sorter, the min-pair merger and the
// row-result consumer.
interface min_pair_merger_if #(
    parameter int WIDTH      = 4,
    parameter int MAX_GROUPS = 8
);
    localparam int GW = $clog2(MAX_GROUPS);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_min0;
    logic [WIDTH-1:0] in_min1;
    logic             in_sign;
    logic             in_last;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_min1;
    logic [WIDTH-1:0] out_min2;
    logic [GW-1:0]    out_min1_grp;
    logic             out_sign;
    logic [GW:0]      out_ngrp;
    logic             out_err;

    modport slave (
        input  in_valid, in_min0, in_min1, in_sign, in_last, out_ready,
        output in_ready, out_valid, out_min1, out_min2, out_min1_grp,
               out_sign, out_ngrp, out_err
    );

    modport master (
        output in_valid, in_min0, in_min1, in_sign, in_last, out_ready,
        input  in_ready, out_valid, out_min1, out_min2, out_min1_grp,
               out_sign, out_ngrp, out_err
    );
endinterface

// File: rtl/min_pair_merger.sv
// Folds per-group (min, second-min) pairs into one running pair per check-node
// row and presents a registered, offset-corrected row result.
module min_pair_merger #(
    parameter int WIDTH      = 4,
    parameter int MAX_GROUPS = 8,
    parameter int OFFSET     = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    min_pair_merger_if.slave   bus
);
    localparam int GW = $clog2(MAX_GROUPS);
    localparam logic [GW:0]    CNT_TRUNC = (GW+1)'(MAX_GROUPS - 1);
    localparam logic [WIDTH:0] OFF_W     = (WIDTH+1)'(OFFSET);

    typedef enum logic { ACC = 1'b0, HOLD = 1'b1 } state_t;

    state_t r_state, w_state_nxt;

    logic [WIDTH-1:0] r_acc1, r_acc2;
    logic [GW-1:0]    r_acc_grp;
    logic             r_acc_sign;
    logic [GW:0]      r_cnt;

    logic [WIDTH-1:0] r_out_min1, r_out_min2;
    logic [GW-1:0]    r_out_grp;
    logic             r_out_sign;
    logic [GW:0]      r_out_ngrp;
    logic             r_out_err;

    logic             w_xfer, w_trunc, w_done;
    logic [WIDTH-1:0] w_m1, w_m2;
    logic [GW-1:0]    w_grp;
    logic             w_sign;
    logic [GW:0]      w_cnt;

    function automatic logic [WIDTH-1:0] f_sat(input logic [WIDTH-1:0] v);
        return ({1'b0, v} > OFF_W) ? WIDTH'({1'b0, v} - OFF_W) : '0;
    endfunction

    assign bus.in_ready = (r_state == ACC) | bus.out_ready;
    assign w_xfer       = bus.in_valid & bus.in_ready;
    assign w_trunc      = w_xfer & ~bus.in_last & (r_cnt == CNT_TRUNC);
    assign w_done       = w_xfer & (bus.in_last | (r_cnt == CNT_TRUNC));

    // r_cnt == 0 marks "no row in progress": the group loads rather than merges.
    always_comb begin
        w_m1   = r_acc1;
        w_m2   = r_acc2;
        w_grp  = r_acc_grp;
        w_sign = r_acc_sign ^ bus.in_sign;
        w_cnt  = r_cnt + 1'b1;
        if (r_cnt == '0) begin
            w_m1   = bus.in_min0;
            w_m2   = bus.in_min1;
            w_grp  = '0;
            w_sign = bus.in_sign;
        end else if (bus.in_min0 < r_acc1) begin
            w_m1  = bus.in_min0;
            w_grp = r_cnt[GW-1:0];
            w_m2  = (r_acc1 < bus.in_min1) ? r_acc1 : bus.in_min1;
        end else if (bus.in_min0 < r_acc2) begin
            w_m2 = bus.in_min0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACC:  if (w_done) w_state_nxt = HOLD;
            HOLD: if (w_done)             w_state_nxt = HOLD;
                  else if (bus.out_ready) w_state_nxt = ACC;
            default: w_state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ACC;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc1     <= '0;
            r_acc2     <= '0;
            r_acc_grp  <= '0;
            r_acc_sign <= 1'b0;
            r_cnt      <= '0;
        end else if (w_done) begin
            r_cnt <= '0;
        end else if (w_xfer) begin
            r_acc1     <= w_m1;
            r_acc2     <= w_m2;
            r_acc_grp  <= w_grp;
            r_acc_sign <= w_sign;
            r_cnt      <= w_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_min1 <= '0;
            r_out_min2 <= '0;
            r_out_grp  <= '0;
            r_out_sign <= 1'b0;
            r_out_ngrp <= '0;
            r_out_err  <= 1'b0;
        end else if (w_done) begin
            r_out_min1 <= f_sat(w_m1);
            r_out_min2 <= f_sat(w_m2);
            r_out_grp  <= w_grp;
            r_out_sign <= w_sign;
            r_out_ngrp <= w_cnt;
            r_out_err  <= w_trunc;
        end
    end

    assign bus.out_valid    = (r_state == HOLD);
    assign bus.out_min1     = r_out_min1;
    assign bus.out_min2     = r_out_min2;
    assign bus.out_min1_grp = r_out_grp;
    assign bus.out_sign     = r_out_sign;
    assign bus.out_ngrp     = r_out_ngrp;
    assign bus.out_err      = r_out_err;
endmodule

// File: tb/tb_min_pair_merger.sv
// Directed bench for min_pair_merger: OFFSET=0 instance for most rows and an
// OFFSET=1 instance for the saturation case.
module tb_min_pair_merger;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    min_pair_merger_if #(.WIDTH(4), .MAX_GROUPS(8)) b0 ();
    min_pair_merger_if #(.WIDTH(4), .MAX_GROUPS(8)) b1 ();

    min_pair_merger #(.WIDTH(4), .MAX_GROUPS(8), .OFFSET(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(b0));
    min_pair_merger #(.WIDTH(4), .MAX_GROUPS(8), .OFFSET(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1));

    // {valid, min1, min2, grp, sign, ngrp, err}
    wire [17:0] res0 = {b0.out_valid, b0.out_min1, b0.out_min2, b0.out_min1_grp,
                        b0.out_sign, b0.out_ngrp, b0.out_err};
    wire [17:0] res1 = {b1.out_valid, b1.out_min1, b1.out_min2, b1.out_min1_grp,
                        b1.out_sign, b1.out_ngrp, b1.out_err};

    task automatic send(input logic [3:0] a, input logic [3:0] b,
                        input logic s, input logic l);
        int t = 0;
        b0.in_valid = 1'b1; b0.in_min0 = a; b0.in_min1 = b;
        b0.in_sign = s; b0.in_last = l;
        while (1) begin
            @(negedge clk);
            if (b0.in_ready) break;
            t++;
            if (t > 20) begin
                checks++; errors++;
                $display("FAIL send_timeout: in_ready=%0b required 1", b0.in_ready);
                break;
            end
        end
        @(posedge clk); #1;
        b0.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (res0 !== 18'h0) begin errors++;
            $display("FAIL reset_outputs: got %h required %h", res0, 18'h0); end
        checks++;
        if (b0.in_ready !== 1'b1) begin errors++;
            $display("FAIL reset_in_ready: got %b required 1", b0.in_ready); end
    endtask

    task automatic test_single();
        b0.out_ready = 1'b1;
        send(4'd3, 4'd5, 1'b1, 1'b1);
        checks++;
        if (res0 !== {1'b1,4'd3,4'd5,3'd0,1'b1,4'd1,1'b0}) begin errors++;
            $display("FAIL single_group: got %h required %h", res0,
                     {1'b1,4'd3,4'd5,3'd0,1'b1,4'd1,1'b0}); end
    endtask

    task automatic test_three_groups();
        send(4'd6, 4'd9, 1'b1, 1'b0);
        send(4'd2, 4'd7, 1'b1, 1'b0);
        send(4'd4, 4'd4, 1'b1, 1'b1);
        checks++;
        if (res0 !== {1'b1,4'd2,4'd4,3'd1,1'b1,4'd3,1'b0}) begin errors++;
            $display("FAIL three_groups: got %h required %h", res0,
                     {1'b1,4'd2,4'd4,3'd1,1'b1,4'd3,1'b0}); end
    endtask

    task automatic test_tie();
        send(4'd3, 4'd8, 1'b0, 1'b0);
        send(4'd3, 4'd5, 1'b1, 1'b1);
        checks++;
        if (res0 !== {1'b1,4'd3,4'd3,3'd0,1'b1,4'd2,1'b0}) begin errors++;
            $display("FAIL tie: got %h required %h", res0,
                     {1'b1,4'd3,4'd3,3'd0,1'b1,4'd2,1'b0}); end
    endtask

    task automatic test_offset();
        b1.in_valid = 1'b1; b1.in_min0 = 4'd1; b1.in_min1 = 4'd2;
        b1.in_sign = 1'b0; b1.in_last = 1'b0;
        @(posedge clk); #1;
        b1.in_min0 = 4'd0; b1.in_min1 = 4'd9; b1.in_last = 1'b1;
        @(posedge clk); #1;
        b1.in_valid = 1'b0;
        checks++;
        if (res1 !== {1'b1,4'd0,4'd0,3'd1,1'b0,4'd2,1'b0}) begin errors++;
            $display("FAIL offset_saturate: got %h required %h", res1,
                     {1'b1,4'd0,4'd0,3'd1,1'b0,4'd2,1'b0}); end
    endtask

    task automatic test_backpressure();
        logic [17:0] held;
        b0.out_ready = 1'b0;
        send(4'd6, 4'd9, 1'b0, 1'b1);
        held = res0;
        checks++;
        if (held !== {1'b1,4'd6,4'd9,3'd0,1'b0,4'd1,1'b0}) begin errors++;
            $display("FAIL bp_result: got %h required %h", held,
                     {1'b1,4'd6,4'd9,3'd0,1'b0,4'd1,1'b0}); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (b0.in_ready !== 1'b0) begin errors++;
                $display("FAIL bp_in_ready cycle %0d: got %b required 0", i, b0.in_ready); end
            checks++;
            if (res0 !== held) begin errors++;
                $display("FAIL bp_stable cycle %0d: got %h required %h", i, res0, held); end
        end
        @(posedge clk); #1;
        b0.out_ready = 1'b1;
        send(4'd7, 4'd7, 1'b0, 1'b1);
        checks++;
        if (res0 !== {1'b1,4'd7,4'd7,3'd0,1'b0,4'd1,1'b0}) begin errors++;
            $display("FAIL bp_drain_and_load: got %h required %h", res0,
                     {1'b1,4'd7,4'd7,3'd0,1'b0,4'd1,1'b0}); end
        @(posedge clk); #1;
        checks++;
        if (b0.out_valid !== 1'b0) begin errors++;
            $display("FAIL bp_drained: out_valid=%b required 0", b0.out_valid); end
    endtask

    task automatic test_truncation();
        logic [3:0] m0 [8] = '{4'd10, 4'd9, 4'd12, 4'd5, 4'd7, 4'd6, 4'd11, 4'd5};
        logic [3:0] m1 [8] = '{4'd12, 4'd11, 4'd13, 4'd14, 4'd8, 4'd6, 4'd11, 4'd9};
        for (int i = 0; i < 8; i++) send(m0[i], m1[i], (i == 0), 1'b0);
        checks++;
        if (res0 !== {1'b1,4'd5,4'd5,3'd3,1'b1,4'd8,1'b1}) begin errors++;
            $display("FAIL truncation: got %h required %h", res0,
                     {1'b1,4'd5,4'd5,3'd3,1'b1,4'd8,1'b1}); end
        send(4'd2, 4'd3, 1'b0, 1'b1);
        checks++;
        if (res0 !== {1'b1,4'd2,4'd3,3'd0,1'b0,4'd1,1'b0}) begin errors++;
            $display("FAIL after_truncation: got %h required %h", res0,
                     {1'b1,4'd2,4'd3,3'd0,1'b0,4'd1,1'b0}); end
    endtask

    task automatic test_reset_midrow();
        @(posedge clk); #1;
        send(4'd1, 4'd1, 1'b1, 1'b0);
        send(4'd2, 4'd2, 1'b1, 1'b0);
        b0.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (res0 !== 18'h0) begin errors++;
            $display("FAIL midrow_reset_outputs: got %h required %h", res0, 18'h0); end
        checks++;
        if (b0.in_ready !== 1'b1) begin errors++;
            $display("FAIL midrow_reset_in_ready: got %b required 1", b0.in_ready); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        b0.out_ready = 1'b1;
        send(4'd4, 4'd6, 1'b0, 1'b1);
        checks++;
        if (res0 !== {1'b1,4'd4,4'd6,3'd0,1'b0,4'd1,1'b0}) begin errors++;
            $display("FAIL fresh_row: got %h required %h", res0,
                     {1'b1,4'd4,4'd6,3'd0,1'b0,4'd1,1'b0}); end
    endtask

    task automatic test_back_to_back();
        send(4'd1, 4'd2, 1'b0, 1'b1);
        checks++;
        if (res0 !== {1'b1,4'd1,4'd2,3'd0,1'b0,4'd1,1'b0}) begin errors++;
            $display("FAIL b2b_row0: got %h required %h", res0,
                     {1'b1,4'd1,4'd2,3'd0,1'b0,4'd1,1'b0}); end
        send(4'd3, 4'd4, 1'b1, 1'b1);
        checks++;
        if (res0 !== {1'b1,4'd3,4'd4,3'd0,1'b1,4'd1,1'b0}) begin errors++;
            $display("FAIL b2b_row1: got %h required %h", res0,
                     {1'b1,4'd3,4'd4,3'd0,1'b1,4'd1,1'b0}); end
        send(4'd9, 4'd10, 1'b0, 1'b0);
        checks++;
        if (b0.out_valid !== 1'b0) begin errors++;
            $display("FAIL b2b_midrow_valid: got %b required 0", b0.out_valid); end
        send(4'd8, 4'd15, 1'b1, 1'b1);
        checks++;
        if (res0 !== {1'b1,4'd8,4'd9,3'd1,1'b1,4'd2,1'b0}) begin errors++;
            $display("FAIL b2b_row2: got %h required %h", res0,
                     {1'b1,4'd8,4'd9,3'd1,1'b1,4'd2,1'b0}); end
    endtask

    initial begin
        b0.in_valid = 1'b0; b0.in_min0 = '0; b0.in_min1 = '0;
        b0.in_sign = 1'b0; b0.in_last = 1'b0; b0.out_ready = 1'b0;
        b1.in_valid = 1'b0; b1.in_min0 = '0; b1.in_min1 = '0;
        b1.in_sign = 1'b0; b1.in_last = 1'b0; b1.out_ready = 1'b1;
        #12 test_reset();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        test_single();
        test_three_groups();
        test_tie();
        test_offset();
        test_backpressure();
        test_truncation();
        test_reset_midrow();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
